can_reg_arb: RTL and testbench

Two-port arbiter that shares the single register port of `can_top_raw` (`reg_re`, `reg_we`, `reg_addr`, `reg_data_in`, `reg_data_out`, `reg_rst`) between two requesters. Port A is the host bus interface (`can_ifc_wb`/`can_ifc_8051` side); port B is an on-chip requester (config sequencer/DMA). It serialises accesses, issues exactly one `reg_re`/`reg_we` strobe per access, and supports bus locking for atomic multi-register sequences such as reset-mode → bus-timing → operating-mode.

---
 rtl/can_reg_arb_if.sv | 14 +
 rtl/can_reg_arb.sv | 170 +++++++++++++++++
 tb/tb_can_reg_arb.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/can_reg_arb_if.sv
// Requester-side handshake bundle for one port of the can_reg_arb register arbiter.
// master = requester (host bus or on-chip sequencer), slave = arbiter.
interface can_reg_arb_if;
  logic       req;
  logic       we;
  logic       lock;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       ack;
  logic [7:0] rdata;

  modport master (output req, we, lock, addr, wdata, input ack, rdata);
  modport slave  (input req, we, lock, addr, wdata, output ack, rdata);
endinterface

// File: rtl/can_reg_arb.sv
// Two-port arbiter sharing the single can_top_raw register port between the host
// interface (A) and an on-chip requester (B), with bus locking for atomic sequences.
module can_reg_arb #(
  parameter int unsigned RD_LAT   = 0,
  parameter int unsigned LOCK_MAX = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  can_reg_arb_if.slave       a_if,
  can_reg_arb_if.slave       b_if,
  output logic               reg_rst_o,
  output logic               reg_re_o,
  output logic               reg_we_o,
  output logic [7:0]         reg_addr_o,
  output logic [7:0]         reg_data_in_o,
  input  logic [7:0]         reg_data_out_i,
  output logic [1:0]         owner_o,
  output logic               lock_err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t      state;
  logic        cur_b;
  logic        lat_we;
  logic        lat_lock;
  logic        locked;
  logic        lock_b;
  logic [15:0] lock_cnt;
  logic        rr_a_first;
  logic [1:0]  wcnt;
  logic        a_ack_r, b_ack_r;
  logic [7:0]  a_rdata_r, b_rdata_r;

  logic        grant_a, grant_b, contend, owner_lock_in;
  logic        sel_we, sel_lock;
  logic [7:0]  sel_addr, sel_wdata;

  assign a_if.ack   = a_ack_r;
  assign b_if.ack   = b_ack_r;
  assign a_if.rdata = a_rdata_r;
  assign b_if.rdata = b_rdata_r;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (locked) begin
      grant_a = !lock_b && a_if.req;
      grant_b =  lock_b && b_if.req;
    end else if (a_if.req && b_if.req) begin
      grant_a =  rr_a_first;
      grant_b = !rr_a_first;
    end else begin
      grant_a = a_if.req;
      grant_b = b_if.req;
    end
  end

  assign contend       = !locked && a_if.req && b_if.req;
  assign owner_lock_in = lock_b ? b_if.lock : a_if.lock;
  assign sel_we        = grant_b ? b_if.we    : a_if.we;
  assign sel_lock      = grant_b ? b_if.lock  : a_if.lock;
  assign sel_addr      = grant_b ? b_if.addr  : a_if.addr;
  assign sel_wdata     = grant_b ? b_if.wdata : a_if.wdata;

  always_ff @(posedge clk_i) begin
    reg_rst_o <= ~rst_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      cur_b         <= 1'b0;
      lat_we        <= 1'b0;
      lat_lock      <= 1'b0;
      locked        <= 1'b0;
      lock_b        <= 1'b0;
      lock_cnt      <= '0;
      rr_a_first    <= 1'b1;
      wcnt          <= '0;
      a_ack_r       <= 1'b0;
      b_ack_r       <= 1'b0;
      a_rdata_r     <= '0;
      b_rdata_r     <= '0;
      reg_re_o      <= 1'b0;
      reg_we_o      <= 1'b0;
      reg_addr_o    <= '0;
      reg_data_in_o <= '0;
      owner_o       <= 2'b00;
      lock_err_o    <= 1'b0;
    end else begin
      a_ack_r  <= 1'b0;
      b_ack_r  <= 1'b0;
      reg_re_o <= 1'b0;
      reg_we_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            cur_b         <= grant_b;
            lat_we        <= sel_we;
            lat_lock      <= sel_lock;
            reg_addr_o    <= sel_addr;
            reg_data_in_o <= sel_wdata;
            reg_we_o      <= sel_we;
            reg_re_o      <= !sel_we;
            owner_o       <= grant_b ? 2'b10 : 2'b01;
            lock_cnt      <= '0;
            // Pointer moves only on contested grants so alternation tracks real conflicts.
            if (contend) rr_a_first <= grant_b;
            state <= ISSUE;
          end else if (locked) begin
            if (!owner_lock_in) begin
              locked   <= 1'b0;
              owner_o  <= 2'b00;
              lock_cnt <= '0;
            end else if (lock_cnt == 16'(LOCK_MAX - 1)) begin
              locked     <= 1'b0;
              owner_o    <= 2'b00;
              lock_err_o <= 1'b1;
              lock_cnt   <= '0;
            end else begin
              lock_cnt <= lock_cnt + 16'd1;
            end
          end
        end
        ISSUE: begin
          if (lat_we || RD_LAT == 0) begin
            if (cur_b) b_ack_r <= 1'b1;
            else       a_ack_r <= 1'b1;
            if (!lat_we) begin
              if (cur_b) b_rdata_r <= reg_data_out_i;
              else       a_rdata_r <= reg_data_out_i;
            end
            state <= ACK;
          end else begin
            wcnt  <= 2'(RD_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wcnt == 2'd0) begin
            if (cur_b) begin
              b_ack_r   <= 1'b1;
              b_rdata_r <= reg_data_out_i;
            end else begin
              a_ack_r   <= 1'b1;
              a_rdata_r <= reg_data_out_i;
            end
            state <= ACK;
          end else begin
            wcnt <= wcnt - 2'd1;
          end
        end
        ACK: begin
          if (lat_lock) begin
            locked <= 1'b1;
            lock_b <= cur_b;
          end else begin
            locked  <= 1'b0;
            owner_o <= 2'b00;
          end
          lock_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_can_reg_arb.sv
// Directed bench for can_reg_arb (RD_LAT=2, LOCK_MAX=8) with a small register-file core model.
module tb_can_reg_arb;
  logic       clk_i;
  logic       rst_i;
  logic       reg_rst_o, reg_re_o, reg_we_o;
  logic [7:0] reg_addr_o, reg_data_in_o, reg_data_out_i;
  logic [1:0] owner_o;
  logic       lock_err_o;

  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned re_cnt;

  can_reg_arb_if a_if ();
  can_reg_arb_if b_if ();

  can_reg_arb #(.RD_LAT(2), .LOCK_MAX(8)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .a_if          (a_if),
    .b_if          (b_if),
    .reg_rst_o     (reg_rst_o),
    .reg_re_o      (reg_re_o),
    .reg_we_o      (reg_we_o),
    .reg_addr_o    (reg_addr_o),
    .reg_data_in_o (reg_data_in_o),
    .reg_data_out_i(reg_data_out_i),
    .owner_o       (owner_o),
    .lock_err_o    (lock_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Core model: data appears two cycles after the read strobe, zero otherwise.
  logic [7:0] mem [256];
  logic       rv1, rv2;
  logic [7:0] ra1, ra2;
  always @(posedge clk_i) begin
    rv1 <= reg_re_o;
    ra1 <= reg_addr_o;
    rv2 <= rv1;
    ra2 <= ra1;
    if (reg_we_o) mem[reg_addr_o] <= reg_data_in_o;
    if (reg_re_o) re_cnt <= re_cnt + 1;
  end
  assign reg_data_out_i = rv2 ? mem[ra2] : 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) if (rst_i) check("re_we_excl", 32'(reg_re_o & reg_we_o), 32'd0);

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_a(input logic req, input logic we, input logic lock, input logic [7:0] addr, input logic [7:0] wdata);
    a_if.req = req; a_if.we = we; a_if.lock = lock; a_if.addr = addr; a_if.wdata = wdata;
  endtask

  task automatic set_b(input logic req, input logic we, input logic lock, input logic [7:0] addr, input logic [7:0] wdata);
    b_if.req = req; b_if.we = we; b_if.lock = lock; b_if.addr = addr; b_if.wdata = wdata;
  endtask

  int unsigned re_base;

  initial begin
    n_cmp = 0; n_err = 0; re_cnt = 0;
    rv1 = 1'b0; rv2 = 1'b0; ra1 = '0; ra2 = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h03] = 8'hA5;
    rst_i = 1'b0;
    set_a(0, 0, 0, 8'h00, 8'h00);
    set_b(0, 0, 0, 8'h00, 8'h00);
    tick(); tick(); tick();

    // Reset state
    check("rst_reg_rst", reg_rst_o, 1);
    check("rst_re", reg_re_o, 0);
    check("rst_we", reg_we_o, 0);
    check("rst_addr", reg_addr_o, 8'h00);
    check("rst_wdata", reg_data_in_o, 8'h00);
    check("rst_owner", owner_o, 2'b00);
    check("rst_acks", {a_if.ack, b_if.ack}, 2'b00);
    check("rst_rdata", {a_if.rdata, b_if.rdata}, 16'h0000);
    check("rst_lock_err", lock_err_o, 0);
    rst_i = 1'b1;
    tick();
    check("rel_reg_rst", reg_rst_o, 0);

    // Single write from A
    set_a(1, 1, 0, 8'h06, 8'h43);
    tick();
    check("w_we_c1", reg_we_o, 1);
    check("w_re_c1", reg_re_o, 0);
    check("w_addr_c1", reg_addr_o, 8'h06);
    check("w_data_c1", reg_data_in_o, 8'h43);
    check("w_owner_c1", owner_o, 2'b01);
    check("w_ack_c1", a_if.ack, 0);
    tick();
    check("w_ack_c2", a_if.ack, 1);
    check("w_we_c2", reg_we_o, 0);
    check("w_back_c2", b_if.ack, 0);
    a_if.req = 1'b0;
    tick();
    check("w_ack_c3", a_if.ack, 0);
    check("w_owner_c3", owner_o, 2'b00);

    // Read from B with two-cycle latency
    re_base = re_cnt;
    set_b(1, 0, 0, 8'h03, 8'h00);
    tick();
    check("r_re_c1", reg_re_o, 1);
    check("r_addr_c1", reg_addr_o, 8'h03);
    check("r_owner_c1", owner_o, 2'b10);
    tick();
    check("r_re_c2", reg_re_o, 0);
    check("r_ack_c2", b_if.ack, 0);
    tick();
    check("r_ack_c3", b_if.ack, 0);
    tick();
    check("r_ack_c4", b_if.ack, 1);
    check("r_rdata_c4", b_if.rdata, 8'hA5);
    check("r_aack_c4", a_if.ack, 0);
    b_if.req = 1'b0;
    tick();
    check("r_re_count", re_cnt - re_base, 1);
    check("r_ack_c5", b_if.ack, 0);
    check("r_rdata_hold", b_if.rdata, 8'hA5);

    // Simultaneous requests: A first after reset
    set_a(1, 1, 0, 8'h00, 8'h11);
    set_b(1, 1, 0, 8'h01, 8'h22);
    tick();
    check("rr1_owner", owner_o, 2'b01);
    check("rr1_addr", reg_addr_o, 8'h00);
    tick();
    check("rr1_aack", a_if.ack, 1);
    check("rr1_back", b_if.ack, 0);
    a_if.req = 1'b0;
    tick();
    check("rr1_idle_owner", owner_o, 2'b00);
    tick();
    check("rr1_b_owner", owner_o, 2'b10);
    check("rr1_b_addr", reg_addr_o, 8'h01);
    check("rr1_b_we", reg_we_o, 1);
    tick();
    check("rr1_b_ack", b_if.ack, 1);
    b_if.req = 1'b0;
    tick();
    check("rr1_mem0", mem[8'h00], 8'h11);
    check("rr1_mem1", mem[8'h01], 8'h22);

    // Second simultaneous pair: B first
    set_a(1, 1, 0, 8'h02, 8'h33);
    set_b(1, 1, 0, 8'h03, 8'h44);
    tick();
    check("rr2_owner", owner_o, 2'b10);
    check("rr2_addr", reg_addr_o, 8'h03);
    tick();
    check("rr2_back", b_if.ack, 1);
    check("rr2_aack", a_if.ack, 0);
    b_if.req = 1'b0;
    tick();
    tick();
    check("rr2_a_owner", owner_o, 2'b01);
    check("rr2_a_addr", reg_addr_o, 8'h02);
    tick();
    check("rr2_a_ack", a_if.ack, 1);
    a_if.req = 1'b0;
    tick();

    // Locked three-write sequence from A while B requests continuously
    set_a(1, 1, 1, 8'h00, 8'h01);
    set_b(1, 1, 0, 8'h07, 8'h55);
    tick();
    check("lk1_owner", owner_o, 2'b01);
    check("lk1_addr", reg_addr_o, 8'h00);
    tick();
    check("lk1_ack", a_if.ack, 1);
    set_a(1, 1, 1, 8'h06, 8'h43);
    tick();
    check("lk_idle1_owner", owner_o, 2'b01);
    tick();
    check("lk2_owner", owner_o, 2'b01);
    check("lk2_addr", reg_addr_o, 8'h06);
    tick();
    check("lk2_ack", a_if.ack, 1);
    set_a(1, 1, 0, 8'h00, 8'h00);
    tick();
    check("lk_idle2_owner", owner_o, 2'b01);
    tick();
    check("lk3_owner", owner_o, 2'b01);
    check("lk3_addr", reg_addr_o, 8'h00);
    tick();
    check("lk3_ack", a_if.ack, 1);
    check("lk3_back", b_if.ack, 0);
    set_a(0, 0, 0, 8'h00, 8'h00);
    tick();
    check("lk_rel_owner", owner_o, 2'b00);
    tick();
    check("lk_b_owner", owner_o, 2'b10);
    check("lk_b_addr", reg_addr_o, 8'h07);
    tick();
    check("lk_b_ack", b_if.ack, 1);
    b_if.req = 1'b0;
    tick();

    // Lock timeout: A holds the lock idle for 8 cycles
    set_a(1, 1, 1, 8'h08, 8'h0F);
    tick();
    check("to_owner_c1", owner_o, 2'b01);
    set_b(1, 1, 0, 8'h09, 8'h66);
    tick();
    check("to_ack_c2", a_if.ack, 1);
    a_if.req = 1'b0;
    for (int i = 3; i <= 10; i++) begin
      tick();
      check($sformatf("to_hold_owner_c%0d", i), owner_o, 2'b01);
      check($sformatf("to_hold_err_c%0d", i), lock_err_o, 0);
    end
    tick();
    check("to_err_set", lock_err_o, 1);
    check("to_owner_rel", owner_o, 2'b00);
    tick();
    check("to_b_owner", owner_o, 2'b10);
    check("to_b_addr", reg_addr_o, 8'h09);
    check("to_b_we", reg_we_o, 1);
    tick();
    check("to_b_ack", b_if.ack, 1);
    set_b(0, 0, 0, 8'h00, 8'h00);
    a_if.lock = 1'b0;
    tick();
    check("to_err_sticky", lock_err_o, 1);

    // Reset during the WAIT phase of a read
    set_a(1, 0, 0, 8'h01, 8'h00);
    tick();
    check("mr_re_c1", reg_re_o, 1);
    tick();
    rst_i = 1'b0;
    a_if.req = 1'b0;
    tick();
    check("mr_ack", a_if.ack, 0);
    check("mr_strobes", {reg_re_o, reg_we_o}, 2'b00);
    check("mr_reg_rst", reg_rst_o, 1);
    check("mr_owner", owner_o, 2'b00);
    check("mr_err_clr", lock_err_o, 0);
    check("mr_b_rdata", b_if.rdata, 8'h00);
    tick();
    check("mr_ack2", a_if.ack, 0);
    rst_i = 1'b1;
    tick();
    check("mr_reg_rst_rel", reg_rst_o, 0);
    set_a(1, 0, 0, 8'h02, 8'h00);
    tick();
    check("mr2_re", reg_re_o, 1);
    check("mr2_addr", reg_addr_o, 8'h02);
    tick();
    tick();
    check("mr2_ack_c3", a_if.ack, 0);
    tick();
    check("mr2_ack_c4", a_if.ack, 1);
    check("mr2_rdata", a_if.rdata, 8'h33);
    a_if.req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
